stage_if_prefetch: RTL and testbench

- Next-generation instruction fetch stage.
- Decouples instruction memory from decode with a parametrised prefetch queue and a pipelined, one-request-per-cycle memory interface.
- Handles redirects from exception/eret (highest priority) and decode-stage branches. Flushes the queue and discards stale in-flight responses on redirect.
- Sits between instruction memory and stage ID; replaces the single-register fetch stage.

---
 rtl/stage_if_prefetch.sv | 196 +++++++++++++++++++
 tb/tb_stage_if_prefetch.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_if_prefetch                                            |
// | Description : Instruction fetch stage with prefetch queue, pipelined       |
// |               one-request-per-cycle memory interface and epoch-tagged      |
// |               redirect handling (exception/eret over branch).              |
// | Options     : IF_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stage_if_prefetch #(
  parameter logic [31:0] RESET_VEC       = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exn,
  input  logic [5:0]  exn_type,
  input  logic        eret,
  input  logic [31:0] elr,
  input  logic        branch,
  input  logic [31:0] branch_dest,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_busy,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int c_QW = $clog2(DEPTH);
  localparam int c_CW = c_QW + 1;
  localparam int c_TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // One extra count of headroom: a redirect may issue without credit.
  localparam int c_OW = $clog2(MAX_OUTSTANDING + 2);

  // Fetch pointer, epoch and pending-redirect state
  logic [31:0]     r_fetch_pc;
  logic            r_epoch;
  logic            r_pend;

  // Prefetch queue storage
  logic [31:0]     r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];
  logic [c_QW-1:0] r_head;
  logic [c_QW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  // In-flight request tags
  logic            r_tag_epoch [MAX_OUTSTANDING];
  logic [31:0]     r_tag_addr  [MAX_OUTSTANDING];
  logic [c_TW-1:0] r_tag_rd;
  logic [c_TW-1:0] r_tag_wr;
  logic [c_OW-1:0] r_outstanding;

  logic            w_redir;
  logic [31:0]     w_target;
  logic            w_credit_ok;
  logic            w_accept;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_epoch_nxt;

  function automatic logic [c_TW-1:0] tag_inc(input logic [c_TW-1:0] p);
    if (p == c_TW'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Redirect detection and target selection (exception/eret beats branch)
  always_comb begin
    w_redir  = exn | branch;
    w_target = branch_dest;
    if (exn && eret) begin
      w_target = elr;
    end else if (exn) begin
      w_target = {RESET_VEC[31:8], exn_type, 2'b00};
    end
  end

  // Credit: queue slots not yet spoken for, and the in-flight limit
  assign w_credit_ok = ((32'(r_count) + 32'(r_outstanding)) < 32'(DEPTH)) &&
                       (32'(r_outstanding) < 32'(MAX_OUTSTANDING));

  // Request is suppressed while reset is asserted
  assign instr_req   = rst_n & (w_redir | r_pend | w_credit_ok);
  assign instr_addr  = w_redir ? w_target : r_fetch_pc;
  assign w_accept    = instr_req & ~instr_busy;
  assign w_epoch_nxt = r_epoch ^ w_redir;

  // A response with nothing outstanding (e.g. after reset) is ignored
  assign w_resp = instr_rvalid & (r_outstanding != '0);
  assign w_push = w_resp & (r_tag_epoch[r_tag_rd] == r_epoch) & ~w_redir;

  assign out_valid = (r_count != '0) & ~w_redir;
  assign out_pc    = r_q_pc[r_head];
  assign out_instr = r_q_instr[r_head];
  assign w_pop     = out_valid & out_ready;

  // Fetch PC advance, epoch toggle and redirect-held-under-busy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_VEC;
      r_epoch    <= 1'b0;
      r_pend     <= 1'b0;
    end else if (w_redir) begin
      r_fetch_pc <= w_accept ? (w_target + 32'd4) : w_target;
      r_epoch    <= w_epoch_nxt;
      r_pend     <= ~w_accept;
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
      r_pend     <= 1'b0;
    end
  end

  // Tag FIFO of {epoch, addr} per accepted request, and outstanding count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag_epoch[i] <= 1'b0;
        r_tag_addr[i]  <= '0;
      end
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_accept) begin
        r_tag_epoch[r_tag_wr] <= w_epoch_nxt;
        r_tag_addr[r_tag_wr]  <= instr_addr;
        r_tag_wr              <= tag_inc(r_tag_wr);
      end
      if (w_resp) begin
        r_tag_rd <= tag_inc(r_tag_rd);
      end
      r_outstanding <= r_outstanding + c_OW'(w_accept) - c_OW'(w_resp);
    end
  end

  // Circular prefetch queue; a redirect empties it and drops same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redir) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_tail]    <= r_tag_addr[r_tag_rd];
        r_q_instr[r_tail] <= instr_data;
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef IF_PERF_EN
  // Accepted-request and decode-starved-cycle counters (free-running, wrap)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (out_ready && !out_valid) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_if_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stage_if_prefetch                                         |
// | Description : Self-checking bench for stage_if_prefetch: directed table,   |
// |               redirect/reset sequences and random traffic vs. a queue      |
// |               based reference model.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stage_if_prefetch;

  localparam logic [31:0] RV    = 32'h0000_1000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  logic        clk;
  logic        rst_n;
  logic        exn;
  logic [5:0]  exn_type;
  logic        eret;
  logic [31:0] elr;
  logic        branch;
  logic [31:0] branch_dest;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_busy;
  logic        instr_rvalid;
  logic [31:0] instr_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  stage_if_prefetch #(
    .RESET_VEC      (RV),
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exn         (exn),
    .exn_type    (exn_type),
    .eret        (eret),
    .elr         (elr),
    .branch      (branch),
    .branch_dest (branch_dest),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_busy  (instr_busy),
    .instr_rvalid(instr_rvalid),
    .instr_data  (instr_data),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Memory: one-cycle response to each accepted request
  bit          mem_pend;
  logic [31:0] mem_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  typedef struct {
    bit          ep;
    logic [31:0] addr;
  } tag_t;
  ent_t        mq[$];
  tag_t        mf[$];
  bit          m_epoch;
  bit          m_pend;
  logic [31:0] m_fpc;

  typedef struct {
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mf.delete();
    m_epoch = 1'b0;
    m_pend  = 1'b0;
    m_fpc   = RV;
  endtask

  // Drive the memory response for this cycle and let outputs settle
  task automatic settle();
    instr_rvalid = mem_pend;
    instr_data   = mem_pend ? memf(mem_addr) : 32'h0;
    #1;
  endtask

  // Compare against the model, update it, then cross the clock edge
  task automatic advance();
    bit          redir;
    bit          ereq;
    bit          eval;
    bit          acc;
    logic [31:0] tgt;
    logic [31:0] eaddr;
    tag_t        t;
    ent_t        e;
    bit          nxt_pend;
    logic [31:0] nxt_addr;
    redir = exn || branch;
    tgt   = exn ? (eret ? elr : {RV[31:8], exn_type, 2'b00}) : branch_dest;
    ereq  = redir || m_pend ||
            ((mq.size() + mf.size()) < DEPTH && mf.size() < MAXO);
    eval  = (mq.size() != 0) && !redir;
    eaddr = redir ? tgt : m_fpc;
    chk("model_req", 32'(instr_req), 32'(ereq));
    chk("model_addr", instr_addr, eaddr);
    chk("model_valid", 32'(out_valid), 32'(eval));
    if (eval) begin
      chk("model_pc", out_pc, mq[0].pc);
      chk("model_instr", out_instr, mq[0].instr);
    end
    acc = ereq && !instr_busy;
    if (eval && out_ready) void'(mq.pop_front());
    if (instr_rvalid && mf.size() > 0) begin
      t = mf.pop_front();
      if (!redir && t.ep == m_epoch) begin
        e.pc    = t.addr;
        e.instr = memf(t.addr);
        mq.push_back(e);
      end
    end
    if (redir) begin
      mq.delete();
      m_epoch = !m_epoch;
      m_pend  = !acc;
      m_fpc   = acc ? tgt + 32'd4 : tgt;
    end else if (acc) begin
      m_pend = 1'b0;
      m_fpc  = m_fpc + 32'd4;
    end
    if (acc) begin
      t.ep   = m_epoch;
      t.addr = eaddr;
      mf.push_back(t);
    end
    nxt_pend = instr_req && !instr_busy;
    nxt_addr = instr_addr;
    @(posedge clk);
    mem_pend = nxt_pend;
    mem_addr = nxt_addr;
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      settle();
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cnt;
    int seen;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    exn          = 1'b0;
    exn_type     = '0;
    eret         = 1'b0;
    elr          = '0;
    branch       = 1'b0;
    branch_dest  = '0;
    instr_busy   = 1'b0;
    instr_rvalid = 1'b0;
    instr_data   = '0;
    out_ready    = 1'b1;
    mem_pend     = 1'b0;
    mem_addr     = '0;

    // Reset release, free-running memory, then a stall and resume
    tbl[0]  = '{1'b1, 1'b1, 32'h1000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h1004, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h1008, 1'b1, 32'h1000};
    tbl[3]  = '{1'b1, 1'b1, 32'h100c, 1'b1, 32'h1004};
    tbl[4]  = '{1'b0, 1'b1, 32'h1010, 1'b1, 32'h1008};
    tbl[5]  = '{1'b0, 1'b1, 32'h1014, 1'b1, 32'h1008};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1008};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1008};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1008};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1008};
    tbl[10] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h1008};
    tbl[11] = '{1'b1, 1'b1, 32'h1018, 1'b1, 32'h100c};
    tbl[12] = '{1'b1, 1'b1, 32'h101c, 1'b1, 32'h1010};
    tbl[13] = '{1'b1, 1'b1, 32'h1020, 1'b1, 32'h1014};
    tbl[14] = '{1'b1, 1'b1, 32'h1024, 1'b1, 32'h1018};
    tbl[15] = '{1'b1, 1'b1, 32'h1028, 1'b1, 32'h101c};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(instr_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      out_ready = tbl[i].rdy;
      settle();
      chk("tbl_req", 32'(instr_req), 32'(tbl[i].req));
      if (tbl[i].req) chk("tbl_addr", instr_addr, tbl[i].addr);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("tbl_pc", out_pc, tbl[i].pc);
        chk("tbl_instr", out_instr, memf(tbl[i].pc));
      end
      advance();
    end

    // Queue fill with decode stalled: exactly DEPTH requests taken
    out_ready   = 1'b0;
    branch      = 1'b1;
    branch_dest = 32'h4000;
    settle();
    chk("fill_br_addr", instr_addr, 32'h4000);
    acc_cnt = (instr_req && !instr_busy) ? 1 : 0;
    advance();
    branch = 1'b0;
    for (int i = 0; i < 9; i++) begin
      settle();
      if (instr_req && !instr_busy) acc_cnt++;
      advance();
    end
    settle();
    chk("fill_accepts", 32'(acc_cnt), 32'd4);
    chk("fill_req", 32'(instr_req), 32'd0);
    advance();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_pc", out_pc, 32'h4000 + 32'(4 * i));
      advance();
    end

    // Branch flush with queue partly full and a request in flight
    out_ready = 1'b0;
    run_cycles(2);
    out_ready   = 1'b1;
    branch      = 1'b1;
    branch_dest = 32'h2000;
    settle();
    chk("br_req", 32'(instr_req), 32'd1);
    chk("br_addr", instr_addr, 32'h2000);
    chk("br_valid_R", 32'(out_valid), 32'd0);
    advance();
    branch = 1'b0;
    settle();
    chk("br_valid_R1", 32'(out_valid), 32'd0);
    advance();
    settle();
    chk("br_valid_R2", 32'(out_valid), 32'd1);
    chk("br_pc_R2", out_pc, 32'h2000);
    advance();

    // Exception and branch together: exception vector wins
    exn         = 1'b1;
    exn_type    = 6'h05;
    branch      = 1'b1;
    branch_dest = 32'h2000;
    settle();
    chk("exn_addr", instr_addr, 32'h1014);
    advance();
    exn    = 1'b0;
    branch = 1'b0;
    seen   = 0;
    settle();
    if (instr_req && instr_addr == 32'h2000) seen++;
    advance();
    settle();
    chk("exn_pc_R2", out_pc, 32'h1014);
    chk("exn_valid_R2", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (instr_req && instr_addr == 32'h2000) seen++;
      advance();
      settle();
    end
    chk("exn_no_branch_fetch", 32'(seen), 32'd0);
    advance();

    // Eret redirect held through three busy cycles
    exn        = 1'b1;
    eret       = 1'b1;
    elr        = 32'h3008;
    instr_busy = 1'b1;
    settle();
    chk("eret_req", 32'(instr_req), 32'd1);
    chk("eret_addr", instr_addr, 32'h3008);
    advance();
    exn  = 1'b0;
    eret = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("eret_hold_req", 32'(instr_req), 32'd1);
      chk("eret_hold_addr", instr_addr, 32'h3008);
      advance();
    end
    instr_busy = 1'b0;
    settle();
    chk("eret_acc_addr", instr_addr, 32'h3008);
    advance();
    settle();
    chk("eret_resp_valid", 32'(out_valid), 32'd0);
    advance();
    settle();
    chk("eret_valid", 32'(out_valid), 32'd1);
    chk("eret_pc", out_pc, 32'h3008);
    advance();

    // Asynchronous reset pulse with a request outstanding
    run_cycles(3);
    settle();
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(instr_req), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mem_pend = 1'b1;
    mem_addr = 32'h0000_5550;
    settle();
    chk("arst_restart_addr", instr_addr, RV);
    chk("arst_restart_req", 32'(instr_req), 32'd1);
    advance();
    settle();
    chk("arst_stale_valid", 32'(out_valid), 32'd0);
    advance();
    settle();
    chk("arst_first_valid", 32'(out_valid), 32'd1);
    chk("arst_first_pc", out_pc, RV);
    advance();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      exn         = ($urandom_range(0, 99) < 3);
      eret        = $urandom_range(0, 1) != 0;
      exn_type    = 6'($urandom());
      elr         = $urandom() & 32'hFFFF_FFFC;
      branch      = ($urandom_range(0, 99) < 6);
      branch_dest = $urandom() & 32'hFFFF_FFFC;
      instr_busy  = ($urandom_range(0, 99) < 25);
      out_ready   = ($urandom_range(0, 99) < 70);
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
